instr_prefetch_buffer: RTL and testbench

//  Front-end fetch block feeding the IF/ID pipeline register. Issues in-order word fetches to a

---
 rtl/fetch_pkg.sv | 11 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/instr_prefetch_buffer.sv | 101 ++++++++++
 tb/tb_instr_prefetch_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types: the {pc,instr} pair buffered for decode and the canonical NOP.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear, occupancy count and a look-ahead head output.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Fetch front end: in-order word fetches to a variable-latency imem, {pc,instr} buffering
// for decode, and redirect handling that flushes the buffer and drops stale responses.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] force_pc,
    input  logic        take_force_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [31:0]  fetch_pc;
    logic [OW-1:0] outst;
    logic [OW-1:0] discard;
    logic [CW-1:0] count;
    logic [OW-1:0] tag_count;
    logic [31:0]  tag_head;
    logic [31:0]  occupancy;
    logic         req_fire;
    logic         resp_fire;
    logic         entry_push;
    fetch_entry_t entry_in;
    fetch_entry_t entry_head;

    assign occupancy      = 32'(count) + 32'(outst);
    assign imem_req_valid = !reset && !take_force_pc && (outst < OW'(MAX_OUTST))
                            && (occupancy < 32'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_fire      = imem_resp_valid;

    assign entry_push     = resp_fire && (discard == '0) && !take_force_pc && !reset;
    assign entry_in.pc    = tag_head;
    assign entry_in.instr = imem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else if (take_force_pc) begin
            // Everything still in flight after this cycle belongs to the abandoned stream.
            fetch_pc <= force_pc;
            outst    <= outst - OW'(resp_fire);
            discard  <= outst - OW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            outst <= outst + OW'(req_fire) - OW'(resp_fire);
            if (resp_fire && (discard != '0)) discard <= discard - 1'b1;
        end
    end

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (take_force_pc),
        .push      (entry_push),
        .push_data (entry_in),
        .pop       (instr_valid && instr_ready),
        .head      (entry_head),
        .count     (count)
    );

    // Tags survive redirects so stale responses still retire their own PC.
    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_fire),
        .head      (tag_head),
        .count     (tag_count)
    );

    assign instr_valid = (count != '0);
    assign pc          = instr_valid ? entry_head.pc : 32'h0;
    assign instr       = instr_valid ? entry_head.instr : RV_NOP;

    assert property (@(posedge clk) disable iff (reset) outst <= OW'(MAX_OUTST));
    assert property (@(posedge clk) disable iff (reset) occupancy <= 32'(DEPTH));
    assert property (@(posedge clk) disable iff (reset) discard <= outst);
    assert property (@(posedge clk) disable iff (reset) !(imem_resp_valid && (outst == '0)));
    assert property (@(posedge clk) disable iff (reset) tag_count == outst);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with an in-order imem model and a delivered-PC log.
module tb_instr_prefetch_buffer;
    localparam logic [31:0] KEY = 32'h1357_9BDF;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] force_pc;
    logic        take_force_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] instr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_q[$];
    logic [31:0] dq_pc[$];
    logic [31:0] dq_instr[$];
    bit          resp_en;
    int          fire_cnt;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_instr_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    always #5 clk = ~clk;

    instr_prefetch_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .force_pc        (force_pc),
        .take_force_pc   (take_force_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .pc              (pc),
        .instr           (instr)
    );

    // One clock cycle: drive the memory response, snapshot outputs, advance, update the imem model.
    task automatic cycle();
        bit          fire_now;
        logic [31:0] fa;
        if (!reset && resp_en && mem_q.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_q[0] ^ KEY;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        s_req_valid   = imem_req_valid;
        s_addr        = imem_req_addr;
        s_instr_valid = instr_valid;
        s_pc          = pc;
        s_instr       = instr;
        fire_now      = imem_req_valid && imem_req_ready;
        fa            = imem_req_addr;
        if (fire_now) fire_cnt++;
        if (!reset && !take_force_pc && instr_valid && instr_ready) begin
            dq_pc.push_back(pc);
            dq_instr.push_back(instr);
        end
        @(posedge clk);
        if (imem_resp_valid) void'(mem_q.pop_front());
        if (fire_now) mem_q.push_back(fa);
        if (reset) mem_q.delete();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; take_force_pc = 1'b0; force_pc = 32'h0;
        imem_req_ready = 1'b1; instr_ready = 1'b1; resp_en = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        mem_q.delete(); dq_pc.delete(); dq_instr.delete(); fire_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; take_force_pc = 1'b0; force_pc = 32'h0;
        imem_req_ready = 1'b1; instr_ready = 1'b1; resp_en = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (s_req_valid !== 1'b0 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_req: valid=%b addr=%h, expected valid=0 addr=00000000", s_req_valid, s_addr);
        end
        n_tests++;
        if (s_instr_valid !== 1'b0 || s_pc !== 32'h0 || s_instr !== NOP) begin
            n_fail++; $display("FAIL rst_head: valid=%b pc=%h instr=%h, expected 0/00000000/00000013", s_instr_valid, s_pc, s_instr);
        end
        reset = 1'b0;
        mem_q.delete(); dq_pc.delete(); dq_instr.delete(); fire_cnt = 0;
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle();
            n_tests++;
            if (s_req_valid !== 1'b1) begin
                n_fail++; $display("FAIL zw_req_valid cycle %0d: got %b, expected 1", k, s_req_valid);
            end
            n_tests++;
            if (k < 2) begin
                if (s_instr_valid !== 1'b0) begin
                    n_fail++; $display("FAIL zw_early_valid cycle %0d: got %b, expected 0", k, s_instr_valid);
                end
            end else if (s_instr_valid !== 1'b1 || s_pc !== 32'(4 * (k - 2)) || s_instr !== (32'(4 * (k - 2)) ^ KEY)) begin
                n_fail++; $display("FAIL zw_stream cycle %0d: valid=%b pc=%h instr=%h, expected pc=%h", k, s_instr_valid, s_pc, s_instr, 32'(4 * (k - 2)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        n_tests++;
        if (fire_cnt !== 4) begin
            n_fail++; $display("FAIL bp_fill: %0d requests accepted, expected 4", fire_cnt);
        end
        n_tests++;
        if (s_req_valid !== 1'b0 || s_instr_valid !== 1'b1 || s_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_full: req_valid=%b instr_valid=%b pc=%h, expected 0/1/00000000", s_req_valid, s_instr_valid, s_pc);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= dq_pc.size()) begin
                n_fail++; $display("FAIL bp_drain[%0d]: missing entry, expected pc=%h", i, 32'(4 * i));
            end else if (dq_pc[i] !== 32'(4 * i) || dq_instr[i] !== (32'(4 * i) ^ KEY)) begin
                n_fail++; $display("FAIL bp_drain[%0d]: pc=%h instr=%h, expected pc=%h", i, dq_pc[i], dq_instr[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0, 32'h4, 32'h100, 32'h104};
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        resp_en = 1'b0;
        cycle();
        n_tests++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'hC) begin
            n_fail++; $display("FAIL ri_second_req: valid=%b addr=%h, expected 1/0000000c", s_req_valid, s_addr);
        end
        take_force_pc = 1'b1; force_pc = 32'h100;
        cycle();
        n_tests++;
        if (s_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL ri_no_req_on_redirect: got %b, expected 0", s_req_valid);
        end
        take_force_pc = 1'b0; resp_en = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= dq_pc.size()) begin
                n_fail++; $display("FAIL ri_deliver[%0d]: missing entry, expected pc=%h", i, exp_pc[i]);
            end else if (dq_pc[i] !== exp_pc[i] || dq_instr[i] !== (exp_pc[i] ^ KEY)) begin
                n_fail++; $display("FAIL ri_deliver[%0d]: pc=%h instr=%h, expected pc=%h", i, dq_pc[i], dq_instr[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_redirect_resp_same_cycle();
        bit saw_stale;
        do_reset();
        cycle();
        take_force_pc = 1'b1; force_pc = 32'h200;
        cycle();
        take_force_pc = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        n_tests++;
        if (dq_pc.size() < 2) begin
            n_fail++; $display("FAIL rs_deliver: %0d entries, expected at least 2", dq_pc.size());
        end else if (dq_pc[0] !== 32'h200 || dq_instr[0] !== (32'h200 ^ KEY) || dq_pc[1] !== 32'h204) begin
            n_fail++; $display("FAIL rs_deliver: pcs %h,%h instr %h, expected 00000200,00000204", dq_pc[0], dq_pc[1], dq_instr[0]);
        end
        saw_stale = 1'b0;
        foreach (dq_pc[i]) if (dq_pc[i] == 32'h0) saw_stale = 1'b1;
        n_tests++;
        if (saw_stale) begin
            n_fail++; $display("FAIL rs_stale: stale pc 00000000 delivered, expected none");
        end
    endtask

    task automatic test_back_to_back();
        bit saw_40;
        do_reset();
        cycle();
        cycle();
        resp_en = 1'b0; take_force_pc = 1'b1; force_pc = 32'h40;
        cycle();
        force_pc = 32'h80;
        cycle();
        n_tests++;
        if (s_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bb_no_req: got %b, expected 0", s_req_valid);
        end
        take_force_pc = 1'b0; resp_en = 1'b1;
        cycle();
        n_tests++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h80) begin
            n_fail++; $display("FAIL bb_target: valid=%b addr=%h, expected 1/00000080", s_req_valid, s_addr);
        end
        for (int k = 0; k < 6; k++) cycle();
        n_tests++;
        if (dq_pc.size() < 2) begin
            n_fail++; $display("FAIL bb_deliver: %0d entries, expected at least 2", dq_pc.size());
        end else if (dq_pc[0] !== 32'h80 || dq_pc[1] !== 32'h84 || dq_instr[0] !== (32'h80 ^ KEY)) begin
            n_fail++; $display("FAIL bb_deliver: pcs %h,%h instr %h, expected 00000080,00000084", dq_pc[0], dq_pc[1], dq_instr[0]);
        end
        saw_40 = 1'b0;
        foreach (dq_pc[i]) if (dq_pc[i] == 32'h40) saw_40 = 1'b1;
        n_tests++;
        if (saw_40) begin
            n_fail++; $display("FAIL bb_first_target: pc 00000040 delivered, expected none");
        end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        cycle();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_tests++;
            if (s_req_valid !== 1'b1 || s_addr !== 32'h4) begin
                n_fail++; $display("FAIL st_hold cycle %0d: valid=%b addr=%h, expected 1/00000004", k, s_req_valid, s_addr);
            end
        end
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (s_instr_valid !== 1'b0 || s_req_valid !== 1'b0 || s_addr !== 32'h0) begin
            n_fail++; $display("FAIL st_reset: instr_valid=%b req_valid=%b addr=%h, expected 0/0/00000000", s_instr_valid, s_req_valid, s_addr);
        end
        n_tests++;
        if (s_pc !== 32'h0 || s_instr !== NOP) begin
            n_fail++; $display("FAIL st_reset_head: pc=%h instr=%h, expected 00000000/00000013", s_pc, s_instr);
        end
        reset = 1'b0;
        dq_pc.delete(); dq_instr.delete();
        for (int k = 0; k < 3; k++) cycle();
        n_tests++;
        if (s_instr_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== KEY) begin
            n_fail++; $display("FAIL st_restart: valid=%b pc=%h instr=%h, expected 1/00000000/%h", s_instr_valid, s_pc, s_instr, KEY);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_resp_same_cycle();
        test_back_to_back();
        test_stall_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
